// File: rtl/ber_test_sequencer.sv
// Sequences one bit-error-rate test over the loopback path: holds the injector
// in reset, then walks warm-up, run and drain windows gating injection and
// checking, then latches the error counts and a pass/fail verdict.
module ber_test_sequencer #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter int unsigned ERR_W        = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] warmup_len,
  input  logic [CNT_W-1:0] run_len,
  input  logic [ERR_W-1:0] threshold,
  input  logic [ERR_W-1:0] inj_errors,
  input  logic [ERR_W-1:0] chk_errors,
  output logic             inj_reset,
  output logic             inj_stop,
  output logic             chk_clear,
  output logic             chk_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             aborted,
  output logic [ERR_W-1:0] res_inj,
  output logic [ERR_W-1:0] res_chk
);

  typedef enum logic [2:0] {
    StIdle, StClear, StWarmup, StRun, StDrain, StLatch, StDone
  } state_e;

  // Counters hold (remaining cycles - 1), so they load length-1 on entry.
  localparam logic [CNT_W-1:0] DrainLoad = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] warmup_q, run_q;
  logic             abort_seen_q, abort_seen_d;
  logic             start_test;
  logic             pass_q, aborted_q;
  logic [ERR_W-1:0] res_inj_q, res_chk_q;
  logic [ERR_W-1:0] err_diff;
  logic             verdict;

  // Checker may never report fewer errors than were injected.
  assign err_diff = chk_errors - inj_errors;
  assign verdict  = (chk_errors >= inj_errors) && (err_diff <= threshold);

  // State, window counter and abort flag registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      abort_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      abort_seen_q <= abort_seen_d;
    end
  end

  // Next-state logic: window sequencing, zero-length skips and abort.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    abort_seen_d = abort_seen_q;
    start_test   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StClear;
          start_test   = 1'b1;
          abort_seen_d = 1'b0;
        end
      end
      StClear: begin
        if (warmup_q != '0) begin
          state_d = StWarmup;
          cnt_d   = warmup_q - CntOne;
        end else if (run_q != '0) begin
          state_d = StRun;
          cnt_d   = run_q - CntOne;
        end else begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end
      end
      StWarmup: begin
        if (abort) begin
          state_d      = StLatch;
          abort_seen_d = 1'b1;
        end else if (cnt_q == '0) begin
          if (run_q != '0) begin
            state_d = StRun;
            cnt_d   = run_q - CntOne;
          end else begin
            state_d = StDrain;
            cnt_d   = DrainLoad;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StRun: begin
        if (abort) begin
          state_d      = StLatch;
          abort_seen_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDrain: begin
        if (abort) begin
          state_d      = StLatch;
          abort_seen_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = StLatch;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StLatch: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Control outputs decoded purely from the current state.
  always_comb begin
    inj_reset = 1'b0;
    inj_stop  = 1'b1;
    chk_clear = 1'b0;
    chk_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle:   inj_reset = 1'b1;
      StClear: begin
        inj_reset = 1'b1;
        chk_clear = 1'b1;
        busy      = 1'b1;
      end
      StWarmup: busy = 1'b1;
      StRun: begin
        inj_stop = 1'b0;
        chk_en   = 1'b1;
        busy     = 1'b1;
      end
      StDrain: begin
        chk_en = 1'b1;
        busy   = 1'b1;
      end
      StLatch:  busy = 1'b1;
      StDone:   done = 1'b1;
      default:  inj_reset = 1'b1;
    endcase
  end

  // Length sampling at test start and result capture in the latch cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      warmup_q  <= '0;
      run_q     <= '0;
      pass_q    <= 1'b0;
      aborted_q <= 1'b0;
      res_inj_q <= '0;
      res_chk_q <= '0;
    end else begin
      if (start_test) begin
        warmup_q  <= warmup_len;
        run_q     <= run_len;
        pass_q    <= 1'b0;
        aborted_q <= 1'b0;
      end
      if (state_q == StLatch) begin
        res_inj_q <= inj_errors;
        res_chk_q <= chk_errors;
        pass_q    <= verdict && !abort_seen_q;
        aborted_q <= abort_seen_q;
      end
    end
  end

  assign pass    = pass_q;
  assign aborted = aborted_q;
  assign res_inj = res_inj_q;
  assign res_chk = res_chk_q;

endmodule
